hazard_sequencer: RTL and testbench
===================================

Name: hazard_sequencer

Overview:
- Hazard and scheduling controller for the 5-stage pipeline's execute stage.
- Generates the ForwardAE/ForwardBE operand-select codes consumed by the execute datapath.
- Detects load-use and control hazards and drives stall/flush to the F/D/E/M pipeline registers.
- Sequences multi-cycle execute operations (mul/div) with an FSM plus countdown, and keeps saturating hazard performance counters.

Parameters:
- MC_LATENCY, 4, total EX-stage cycles occupied by a multi-cycle op; legal range 1..16.
- PERF_W, 16, width of each performance counter.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous reset, active-high
- Rs1D  input  5  rs1 index of instruction in Decode
- Rs2D  input  5  rs2 index of instruction in Decode
- Rs1E  input  5  rs1 index of instruction in Execute
- Rs2E  input  5  rs2 index of instruction in Execute
- RdE  input  5  destination index in Execute
- RdM  input  5  destination index in Memory
- RdW  input  5  destination index in Writeback
- RegWriteM  input  1  Memory-stage instruction writes a register
- RegWriteW  input  1  Writeback-stage instruction writes a register
- MemReadE  input  1  Execute-stage instruction is a load
- BranchE  input  1  Execute-stage instruction is a conditional branch
- JumpE  input  1  Execute-stage instruction is jal/jalr
- cond_trueE  input  1  branch condition met, from execute
- MultiCycleE  input  1  Execute-stage instruction is a multi-cycle op
- ForwardAE  output  2  SrcA select: 00 regfile, 01 ResultW, 10 ALUResultM
- ForwardBE  output  2  SrcB select, same encoding
- StallF  output  1  hold PC
- StallD  output  1  hold IF/ID register
- StallE  output  1  hold ID/EX register
- FlushD  output  1  bubble IF/ID register
- FlushE  output  1  bubble ID/EX register
- FlushM  output  1  bubble EX/MEM register
- PCSrcE  output  1  redirect PC to PCTargetE
- MCStartE  output  1  one-cycle pulse: multi-cycle unit latches operands
- MCBusy  output  1  FSM in BUSY
- PerfLoadUse  output  PERF_W  count of load-use stall cycles
- PerfFlush  output  PERF_W  count of taken redirects

Behaviour:
- Forwarding (combinational):
  - ForwardAE=10 if RegWriteM and RdM!=0 and RdM==Rs1E.
  - Else ForwardAE=01 if RegWriteW and RdW!=0 and RdW==Rs1E.
  - Else ForwardAE=00.
  - ForwardBE is identical using Rs2E. The M stage takes priority over W.
- Load-use hazard: lu = MemReadE and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
- Redirect: red = JumpE or (BranchE and cond_trueE).
- FSM states: IDLE and BUSY, with a 4-bit counter cnt.
  - IDLE, MultiCycleE=1, MC_LATENCY>1: mcs=1, MCStartE=1, cnt<=MC_LATENCY-2, next state BUSY.
  - IDLE, MultiCycleE=1, MC_LATENCY=1: MCStartE=1, no stall, stay IDLE.
  - BUSY, cnt!=0: mcs=1, cnt<=cnt-1.
  - BUSY, cnt==0: mcs=0, next state IDLE. Result is valid this cycle and EX advances.
  - Net effect: the op holds EX for exactly MC_LATENCY cycles, with MC_LATENCY-1 stall cycles.
  - MultiCycleE is ignored while in BUSY. MCStartE is never asserted in BUSY.
- Output priority, highest first:
  1. mcs: StallF=StallD=StallE=1, FlushM=1, PCSrcE=0, FlushD=FlushE=0. lu is masked.
  2. red: PCSrcE=1, FlushD=FlushE=1, StallF=StallD=0. A concurrent lu is discarded.
  3. lu: StallF=StallD=1, FlushE=1.
  4. Otherwise all stall/flush outputs are 0.
- MCBusy = (state==BUSY).
- Counters:
  - PerfLoadUse increments on each cycle where lu is applied (priority 3).
  - PerfFlush increments on each cycle with PCSrcE=1.
  - Both saturate at all-ones, with no wrap.
- Reset (async, rst=1):
  - state<=IDLE, cnt<=0, both counters <=0.
  - While rst=1, all stall/flush outputs, PCSrcE, MCStartE and MCBusy are forced to 0. ForwardAE/BE remain combinational.
  - Reset during BUSY aborts the op; no stall is asserted on the first cycle after release.
- x0 never forwards or stalls, regardless of the write-enables.

Test Plan:
- RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=0 -> ForwardAE=10, ForwardBE=00. Then RegWriteM=0 -> ForwardAE=01.
- MemReadE=1, RdE=7, Rs2D=7, one cycle -> StallF=StallD=FlushE=1 and PerfLoadUse 0->1. Repeat with RdE=0 -> no stall.
- BranchE=1, cond_trueE=1, with lu also true -> PCSrcE=FlushD=FlushE=1, StallF=StallD=0, PerfFlush increments, PerfLoadUse unchanged.
- MC_LATENCY=4, MultiCycleE=1 at cycle 0 -> MCStartE=1 in cycle 0 only. Stalls and FlushM high in cycles 0-2, low in cycle 3. MCBusy high in cycles 1-3. Back to IDLE at cycle 4.
- During BUSY (cycle 1), JumpE=1 and lu=1 -> PCSrcE=0, FlushE=0, PerfFlush and PerfLoadUse unchanged.
- Assert rst in BUSY cycle 2 -> MCBusy and stalls drop immediately. After release with MultiCycleE=0, outputs stay idle. Drive PerfFlush to saturation -> holds 16'hFFFF.

Source files
------------

// File: rtl/hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : hazard_sequencer
// Brief    : Execute-stage hazard controller for a 5-stage pipeline. It
//            generates the operand forwarding selects, detects load-use and
//            control hazards, sequences multi-cycle execute operations, and
//            keeps saturating hazard performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_sequencer #(
   parameter int MC_LATENCY = 4,
   parameter int PERF_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        Rs1D,
   input  logic [4:0]        Rs2D,
   input  logic [4:0]        Rs1E,
   input  logic [4:0]        Rs2E,
   input  logic [4:0]        RdE,
   input  logic [4:0]        RdM,
   input  logic [4:0]        RdW,
   input  logic              RegWriteM,
   input  logic              RegWriteW,
   input  logic              MemReadE,
   input  logic              BranchE,
   input  logic              JumpE,
   input  logic              cond_trueE,
   input  logic              MultiCycleE,
   output logic [1:0]        ForwardAE,
   output logic [1:0]        ForwardBE,
   output logic              StallF,
   output logic              StallD,
   output logic              StallE,
   output logic              FlushD,
   output logic              FlushE,
   output logic              FlushM,
   output logic              PCSrcE,
   output logic              MCStartE,
   output logic              MCBusy,
   output logic [PERF_W-1:0] PerfLoadUse,
   output logic [PERF_W-1:0] PerfFlush
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // BUSY covers the remaining MC_LATENCY-1 cycles; the first is spent in IDLE.
   localparam logic [3:0] C_CNT_INIT = (MC_LATENCY > 1) ? 4'(MC_LATENCY - 2) : 4'd0;
   localparam bit         C_MULTI    = (MC_LATENCY > 1);
   localparam logic [PERF_W-1:0] C_PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

   state_t            r_state;
   state_t            w_state_next;
   logic [3:0]        r_cnt;
   logic [3:0]        w_cnt_next;
   logic              w_mcs;
   logic              w_mcstart;
   logic              w_lu;
   logic              w_red;
   logic              w_lu_applied;
   logic [PERF_W-1:0] r_perf_lu;
   logic [PERF_W-1:0] r_perf_fl;

   // Forwarding selects: Memory stage wins over Writeback; x0 never forwards.
   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
         ForwardAE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
         ForwardAE = 2'b01;
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
         ForwardBE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
         ForwardBE = 2'b01;
   end

   assign w_lu  = MemReadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
   assign w_red = JumpE || (BranchE && cond_trueE);

   // Multi-cycle sequencer state and countdown registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   // Next-state logic; MultiCycleE is only sampled in IDLE.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_mcs        = 1'b0;
      w_mcstart    = 1'b0;
      case (r_state)
         IDLE: begin
            if (MultiCycleE) begin
               w_mcstart = 1'b1;
               if (C_MULTI) begin
                  w_mcs        = 1'b1;
                  w_cnt_next   = C_CNT_INIT;
                  w_state_next = BUSY;
               end
            end
         end
         BUSY: begin
            if (r_cnt != 4'd0) begin
               w_mcs      = 1'b1;
               w_cnt_next = r_cnt - 4'd1;
            end else begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Prioritised stall/flush outputs, all held low while reset is asserted.
   always_comb begin
      StallF   = 1'b0;
      StallD   = 1'b0;
      StallE   = 1'b0;
      FlushD   = 1'b0;
      FlushE   = 1'b0;
      FlushM   = 1'b0;
      PCSrcE   = 1'b0;
      MCStartE = 1'b0;
      MCBusy   = 1'b0;
      w_lu_applied = 1'b0;
      if (!rst) begin
         MCStartE = w_mcstart;
         MCBusy   = (r_state == BUSY);
         if (w_mcs) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            FlushM = 1'b1;
         end else if (w_red) begin
            PCSrcE = 1'b1;
            FlushD = 1'b1;
            FlushE = 1'b1;
         end else if (w_lu) begin
            StallF       = 1'b1;
            StallD       = 1'b1;
            FlushE       = 1'b1;
            w_lu_applied = 1'b1;
         end
      end
   end

   // Saturating performance counters for applied load-use stalls and redirects.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_lu <= '0;
         r_perf_fl <= '0;
      end else begin
         if (w_lu_applied && (r_perf_lu != {PERF_W{1'b1}}))
            r_perf_lu <= r_perf_lu + C_PERF_ONE;
         if (PCSrcE && (r_perf_fl != {PERF_W{1'b1}}))
            r_perf_fl <= r_perf_fl + C_PERF_ONE;
      end
   end

   assign PerfLoadUse = r_perf_lu;
   assign PerfFlush   = r_perf_fl;

endmodule
`default_nettype wire

// File: tb/tb_hazard_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_sequencer
// Brief    : Directed self-checking bench for hazard_sequencer with a
//            scoreboard queue of expected outputs per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_sequencer;

   localparam int PW = 8;

   // Control vector: {FA, FB, StallF, StallD, StallE, FlushD, FlushE, FlushM, PCSrcE, MCStartE, MCBusy}
   localparam logic [8:0] C_IDLE = 9'b000_000_000;
   localparam logic [8:0] C_LU   = 9'b110_010_000;
   localparam logic [8:0] C_RED  = 9'b000_110_100;
   localparam logic [8:0] C_MC0  = 9'b111_001_010;
   localparam logic [8:0] C_MCB  = 9'b111_001_001;
   localparam logic [8:0] C_MCL  = 9'b000_000_001;
   localparam logic [8:0] C_MCLR = 9'b000_110_101;

   typedef struct packed {
      logic [12:0]   ctl;
      logic [PW-1:0] lu;
      logic [PW-1:0] fl;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic RegWriteM, RegWriteW, MemReadE, BranchE, JumpE, cond_trueE, MultiCycleE;
   logic [1:0] ForwardAE, ForwardBE;
   logic StallF, StallD, StallE, FlushD, FlushE, FlushM, PCSrcE, MCStartE, MCBusy;
   logic [PW-1:0] PerfLoadUse, PerfFlush;

   exp_t q[$];
   int checks = 0;
   int errors = 0;
   logic [PW-1:0] e_lu = '0;
   logic [PW-1:0] e_fl = '0;

   always #5 clk = ~clk;

   hazard_sequencer #(.MC_LATENCY(4), .PERF_W(PW)) dut (
      .clk(clk), .rst(rst),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReadE(MemReadE),
      .BranchE(BranchE), .JumpE(JumpE), .cond_trueE(cond_trueE),
      .MultiCycleE(MultiCycleE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE),
      .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
      .PCSrcE(PCSrcE), .MCStartE(MCStartE), .MCBusy(MCBusy),
      .PerfLoadUse(PerfLoadUse), .PerfFlush(PerfFlush)
   );

   task automatic clear_inputs();
      Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
      RegWriteM = 0; RegWriteW = 0; MemReadE = 0; BranchE = 0; JumpE = 0;
      cond_trueE = 0; MultiCycleE = 0;
   endtask

   // Called with inputs already driven (away from posedge): push expectation,
   // compare 1ns later, then advance across one rising edge to the next negedge.
   task automatic step(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [8:0] ctl, input bit lu_inc, input bit fl_inc);
      exp_t e;
      exp_t o;
      e.ctl = {fa, fb, ctl};
      e.lu  = e_lu;
      e.fl  = e_fl;
      q.push_back(e);
      #1;
      o.ctl = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM,
               PCSrcE, MCStartE, MCBusy};
      o.lu  = PerfLoadUse;
      o.fl  = PerfFlush;
      e = q.pop_front();
      checks++;
      assert (o.ctl === e.ctl) else begin
         errors++;
         $error("FAIL %s ctl observed=%b expected=%b", tag, o.ctl, e.ctl);
      end
      checks++;
      assert ({o.lu, o.fl} === {e.lu, e.fl}) else begin
         errors++;
         $error("FAIL %s perf observed lu=%0d fl=%0d expected lu=%0d fl=%0d",
                tag, o.lu, o.fl, e.lu, e.fl);
      end
      @(negedge clk);
      if (lu_inc && e_lu != {PW{1'b1}}) e_lu = e_lu + 1'b1;
      if (fl_inc && e_fl != {PW{1'b1}}) e_fl = e_fl + 1'b1;
   endtask

   initial begin
      clear_inputs();
      rst = 1'b1;
      // Reset: hazards and MC request present, yet all controls stay low; forwarding live.
      MemReadE = 1; RdE = 7; Rs2D = 7; JumpE = 1; MultiCycleE = 1;
      RegWriteM = 1; RdM = 3; Rs1E = 3;
      step("reset", 2'b10, 2'b00, C_IDLE, 0, 0);
      rst = 1'b0;
      clear_inputs();

      // Forwarding priority M over W, then W only, then both operands, then x0.
      RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 0;
      step("fwd_m", 2'b10, 2'b00, C_IDLE, 0, 0);
      RegWriteM = 0;
      step("fwd_w", 2'b01, 2'b00, C_IDLE, 0, 0);
      RegWriteM = 1; RdM = 6; Rs2E = 6;
      step("fwd_ab", 2'b01, 2'b10, C_IDLE, 0, 0);
      RdM = 0; RdW = 0; Rs1E = 0; Rs2E = 0;
      step("fwd_x0", 2'b00, 2'b00, C_IDLE, 0, 0);
      clear_inputs();

      // Load-use via rs2, x0 destination, then via rs1.
      MemReadE = 1; RdE = 7; Rs2D = 7;
      step("lu_rs2", 2'b00, 2'b00, C_LU, 1, 0);
      RdE = 0; Rs2D = 0;
      step("lu_x0", 2'b00, 2'b00, C_IDLE, 0, 0);
      RdE = 9; Rs1D = 9;
      step("lu_rs1", 2'b00, 2'b00, C_LU, 1, 0);
      RdE = 9; Rs1D = 8; Rs2D = 10;
      step("lu_nomatch", 2'b00, 2'b00, C_IDLE, 0, 0);

      // Redirect beats load-use; untaken branch leaves load-use in force.
      Rs1D = 9; BranchE = 1; cond_trueE = 1;
      step("red_lu", 2'b00, 2'b00, C_RED, 0, 1);
      cond_trueE = 0;
      step("untaken_lu", 2'b00, 2'b00, C_LU, 1, 0);
      clear_inputs();

      // Multi-cycle op of 4 cycles; concurrent hazards masked while stalled.
      MultiCycleE = 1;
      step("mc_c0", 2'b00, 2'b00, C_MC0, 0, 0);
      JumpE = 1; MemReadE = 1; RdE = 4; Rs1D = 4;
      step("mc_c1", 2'b00, 2'b00, C_MCB, 0, 0);
      step("mc_c2", 2'b00, 2'b00, C_MCB, 0, 0);
      MultiCycleE = 0; MemReadE = 0;
      step("mc_c3_red", 2'b00, 2'b00, C_MCLR, 0, 1);
      JumpE = 0;
      step("mc_c4", 2'b00, 2'b00, C_IDLE, 0, 0);

      // Reset during BUSY aborts the op and clears counters.
      MultiCycleE = 1;
      step("mc2_c0", 2'b00, 2'b00, C_MC0, 0, 0);
      MultiCycleE = 0;
      step("mc2_c1", 2'b00, 2'b00, C_MCB, 0, 0);
      rst = 1'b1;
      e_lu = '0; e_fl = '0;
      step("rst_busy", 2'b00, 2'b00, C_IDLE, 0, 0);
      rst = 1'b0;
      step("post_rst0", 2'b00, 2'b00, C_IDLE, 0, 0);
      step("post_rst1", 2'b00, 2'b00, C_IDLE, 0, 0);

      // Counter saturation for both counters.
      JumpE = 1;
      for (int i = 0; i < (1 << PW) + 4; i++) step("sat_fl", 2'b00, 2'b00, C_RED, 0, 1);
      JumpE = 0; MemReadE = 1; RdE = 12; Rs2D = 12;
      for (int i = 0; i < (1 << PW) + 4; i++) step("sat_lu", 2'b00, 2'b00, C_LU, 1, 0);
      clear_inputs();
      step("sat_hold", 2'b00, 2'b00, C_IDLE, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
